program_memory: RTL and testbench
=================================

PROGRAM_MEMORY -- requirements
Module: program_memory

Interface
REQ-001 Parameter ADDR_W, default 4, SHALL set address width; depth DEPTH = 2**ADDR_W.
REQ-002 Parameter INSTR_W, default 8, SHALL set stored word width (opcode plus operand).
REQ-003 Parameter OPND_W, default 4, SHALL set operand/data width; OPND_W <= INSTR_W.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high (ports clk, reset).
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 load_mode  in  1  1 = request program-load phase, 0 = request run phase.
REQ-008 ld_valid  in  1  loader word valid.
REQ-009 ld_ready  out  1  block accepts loader word.
REQ-010 ld_auto  in  1  1 = use internal auto-increment pointer; 0 = use ld_addr.
REQ-011 ld_addr  in  ADDR_W  explicit load address.
REQ-012 ld_data  in  INSTR_W  load word.
REQ-013 ld_count  out  ADDR_W+1  words accepted since entering LOAD, saturating at DEPTH.
REQ-014 ld_wrap  out  1  sticky: auto pointer wrapped.
REQ-015 run_en  out  1  high when state is RUN.
REQ-016 mar_addr  in  ADDR_W  CPU address from MAR.
REQ-017 ce_ir / ce_a / ce_tmp  in  1 each  CPU read strobes to IR / A / TMP.
REQ-018 we_a  in  1  CPU write strobe from A register.
REQ-019 wr_data  in  OPND_W  operand from A register.
REQ-020 ir_q  out  INSTR_W  registered word for IR.
REQ-021 a_q, tmp_q  out  OPND_W each  registered low OPND_W bits for A, TMP.
REQ-022 err  out  1  sticky protocol error.

Function
REQ-023 States SHALL be IDLE, LOAD, RUN; reset enters IDLE.
REQ-024 IDLE/RUN -> LOAD when load_mode=1; LOAD -> RUN when load_mode=0; IDLE -> RUN when load_mode=0 for one cycle after reset release.
REQ-025 ld_ready SHALL equal 1 only in LOAD; a word is written at the edge where ld_valid && ld_ready.
REQ-026 Write address SHALL be ld_addr when ld_auto=0, else internal pointer; pointer cleared on LOAD entry, increments per accepted auto word, wraps DEPTH-1 -> 0 setting ld_wrap.
REQ-027 ld_count and ld_wrap SHALL clear on each LOAD entry; ld_count saturates at DEPTH.
REQ-028 In RUN, each asserted ce_* SHALL load its output from mem[mar_addr] at the edge (1-cycle latency); simultaneous strobes all load; unasserted outputs hold.
REQ-029 In RUN, we_a SHALL overwrite low OPND_W bits of mem[mar_addr], upper bits preserved.
REQ-030 Read and we_a to same address in one cycle SHALL return old data (read-before-write).
REQ-031 ce_* or we_a outside RUN SHALL be ignored (no memory change, outputs hold) and set err; ld_valid outside LOAD SHALL be ignored and set err.
REQ-032 err SHALL clear only on reset.

Reset
REQ-033 Reset SHALL set state IDLE, ld_ready 0, ld_count 0, ld_wrap 0, run_en 0, ir_q 0, a_q 0, tmp_q 0, err 0, pointer 0.
REQ-034 Reset SHALL NOT clear memory contents; reset mid-load abandons the current handshake, earlier writes persist.

Structure
REQ-035 Package program_memory_pkg SHALL hold the state enum and default ADDR_W/INSTR_W/OPND_W constants.
REQ-036 Auto-increment pointer, wrap flag and ld_count SHALL live in sub-module load_addr_gen.

Verification
REQ-037 Explicit load 9h=08h, Ah=0Bh, 0h=79h, then RUN, ce_ir at mar 0 -> ir_q=79h next cycle; ce_a at 9 -> a_q=8h.
REQ-038 Auto load 17 words 00h..10h -> mem[0]=10h, mem[1]=01h, ld_wrap=1, ld_count=16.
REQ-039 mem[9]=78h, RUN, we_a wr_data=5h at 9 with ce_ir -> ir_q=78h, later read -> 75h.
REQ-040 ce_a during LOAD -> a_q unchanged, err=1; reset -> err=0.
REQ-041 Reset after 3 auto writes -> IDLE, ld_count=0, first 3 words retained on readback.
REQ-042 ADDR_W=6, INSTR_W=12, OPND_W=6: load 3Fh=ABCh, read tmp_q=3Ch.

Source files
------------

// File: rtl/program_memory_pkg.sv
// Shared types and default geometry for the program memory block.
package program_memory_pkg;

    localparam int unsigned DEF_ADDR_W  = 4;
    localparam int unsigned DEF_INSTR_W = 8;
    localparam int unsigned DEF_OPND_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/program_memory_load_addr_gen.sv
// Loader bookkeeping: auto-increment write pointer, wrap flag and accepted-word count.
module load_addr_gen #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic              auto_inc,
    output logic [ADDR_W-1:0] ptr,
    output logic [ADDR_W:0]   count,
    output logic              wrap
);

    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    // Clear on reset or LOAD entry; count every accepted word, advance pointer on auto words only.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ptr   <= '0;
            count <= '0;
            wrap  <= 1'b0;
        end else if (accept) begin
            if (count != FULL) begin
                count <= count + 1'b1;
            end
            if (auto_inc) begin
                ptr <= ptr + 1'b1;
                if (&ptr) begin
                    wrap <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/program_memory.sv
// Loadable program/data memory with LOAD/RUN phases and CPU read/write strobes.
module program_memory
    import program_memory_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned INSTR_W = DEF_INSTR_W,
    parameter int unsigned OPND_W  = DEF_OPND_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_mode,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic               ld_auto,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [INSTR_W-1:0] ld_data,
    output logic [ADDR_W:0]    ld_count,
    output logic               ld_wrap,
    output logic               run_en,
    input  logic [ADDR_W-1:0]  mar_addr,
    input  logic               ce_ir,
    input  logic               ce_a,
    input  logic               ce_tmp,
    input  logic               we_a,
    input  logic [OPND_W-1:0]  wr_data,
    output logic [INSTR_W-1:0] ir_q,
    output logic [OPND_W-1:0]  a_q,
    output logic [OPND_W-1:0]  tmp_q,
    output logic               err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    state_t              state;
    logic [INSTR_W-1:0]  mem [DEPTH];
    logic                in_load;
    logic                in_run;
    logic                load_entry;
    logic                accept;
    logic                cpu_access;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   wr_addr;

    assign in_load    = (state == ST_LOAD);
    assign in_run     = (state == ST_RUN);
    assign load_entry = !in_load && load_mode;
    assign accept     = ld_valid && in_load;
    assign cpu_access = ce_ir || ce_a || ce_tmp || we_a;
    assign wr_addr    = ld_auto ? ptr : ld_addr;

    load_addr_gen #(
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .clear    (load_entry),
        .accept   (accept),
        .auto_inc (ld_auto),
        .ptr      (ptr),
        .count    (ld_count),
        .wrap     (ld_wrap)
    );

    // Phase sequencing; ld_ready/run_en are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ld_ready <= 1'b0;
            run_en   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_RUN: begin
                    if (load_mode) begin
                        state    <= ST_LOAD;
                        ld_ready <= 1'b1;
                        run_en   <= 1'b0;
                    end else begin
                        state    <= ST_RUN;
                        ld_ready <= 1'b0;
                        run_en   <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!load_mode) begin
                        state    <= ST_RUN;
                        ld_ready <= 1'b0;
                        run_en   <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    ld_ready <= 1'b0;
                    run_en   <= 1'b0;
                end
            endcase
        end
    end

    // Storage: full-word loader writes in LOAD, operand-only CPU writes in RUN; never cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (accept) begin
                mem[wr_addr] <= ld_data;
            end else if (in_run && we_a) begin
                mem[mar_addr][OPND_W-1:0] <= wr_data;
            end
        end
    end

    // CPU read registers; non-blocking reads see pre-write data on a same-address we_a.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q  <= '0;
            a_q   <= '0;
            tmp_q <= '0;
        end else if (in_run) begin
            if (ce_ir) begin
                ir_q <= mem[mar_addr];
            end
            if (ce_a) begin
                a_q <= mem[mar_addr][OPND_W-1:0];
            end
            if (ce_tmp) begin
                tmp_q <= mem[mar_addr][OPND_W-1:0];
            end
        end
    end

    // Sticky protocol error for strobes issued in the wrong phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if ((cpu_access && !in_run) || (ld_valid && !in_load)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_program_memory.sv
// Self-checking bench for program_memory: directed table, hand sequences, randomized run vs. reference model.
module tb_program_memory;

    localparam int S_IDLE = 0;
    localparam int S_LOAD = 1;
    localparam int S_RUN  = 2;

    logic       clk = 1'b0;
    logic       reset, load_mode, ld_valid, ld_auto;
    logic [3:0] ld_addr, mar_addr, wr_data;
    logic [7:0] ld_data;
    logic       ce_ir, ce_a, ce_tmp, we_a;
    logic       ld_ready, ld_wrap, run_en, err;
    logic [4:0] ld_count;
    logic [7:0] ir_q;
    logic [3:0] a_q, tmp_q;

    logic        b_reset, b_load_mode, b_ld_valid, b_ld_auto;
    logic [5:0]  b_ld_addr, b_mar_addr, b_wr_data;
    logic [11:0] b_ld_data;
    logic        b_ce_ir, b_ce_a, b_ce_tmp, b_we_a;
    logic        b_ld_ready, b_ld_wrap, b_run_en, b_err;
    logic [6:0]  b_ld_count;
    logic [11:0] b_ir_q;
    logic [5:0]  b_a_q, b_tmp_q;

    int nvec = 0;
    int nerr = 0;

    // reference model state
    int         m_state;
    int         m_ptr, m_cnt;
    bit         m_wrap, m_err;
    logic [7:0] m_mem [16];
    bit         m_known [16];
    logic [7:0] m_ir;
    logic [3:0] m_a, m_tmp;
    bit         m_ir_k, m_a_k, m_tmp_k;

    always #5 clk = ~clk;

    program_memory #(.ADDR_W(4), .INSTR_W(8), .OPND_W(4)) dut (
        .clk(clk), .reset(reset), .load_mode(load_mode), .ld_valid(ld_valid),
        .ld_ready(ld_ready), .ld_auto(ld_auto), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_count(ld_count), .ld_wrap(ld_wrap), .run_en(run_en), .mar_addr(mar_addr),
        .ce_ir(ce_ir), .ce_a(ce_a), .ce_tmp(ce_tmp), .we_a(we_a), .wr_data(wr_data),
        .ir_q(ir_q), .a_q(a_q), .tmp_q(tmp_q), .err(err)
    );

    program_memory #(.ADDR_W(6), .INSTR_W(12), .OPND_W(6)) dut_wide (
        .clk(clk), .reset(b_reset), .load_mode(b_load_mode), .ld_valid(b_ld_valid),
        .ld_ready(b_ld_ready), .ld_auto(b_ld_auto), .ld_addr(b_ld_addr), .ld_data(b_ld_data),
        .ld_count(b_ld_count), .ld_wrap(b_ld_wrap), .run_en(b_run_en), .mar_addr(b_mar_addr),
        .ce_ir(b_ce_ir), .ce_a(b_ce_a), .ce_tmp(b_ce_tmp), .we_a(b_we_a), .wr_data(b_wr_data),
        .ir_q(b_ir_q), .a_q(b_a_q), .tmp_q(b_tmp_q), .err(b_err)
    );

    typedef struct {
        bit         rst, lm, v, au;
        logic [3:0] addr;
        logic [7:0] data;
        logic [3:0] mar;
        bit         cir, ca, ct, we;
        logic [3:0] wd;
        logic [7:0] e_ir;
        logic [3:0] e_a, e_tmp;
        bit         e_err, e_run;
    } vec_t;

    vec_t tbl [18];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic idle_inputs();
        reset = 1'b0; load_mode = 1'b0; ld_valid = 1'b0; ld_auto = 1'b0;
        ld_addr = '0; ld_data = '0; mar_addr = '0;
        ce_ir = 1'b0; ce_a = 1'b0; ce_tmp = 1'b0; we_a = 1'b0; wr_data = '0;
    endtask

    // One clock: advance the model from the pre-edge inputs, then compare all outputs.
    task automatic tick();
        bit         r, lm, v, au, cir, ca, ct, we;
        logic [3:0] addr, mar, wd;
        logic [7:0] data;
        int         wa;
        r = reset; lm = load_mode; v = ld_valid; au = ld_auto;
        cir = ce_ir; ca = ce_a; ct = ce_tmp; we = we_a;
        addr = ld_addr; mar = mar_addr; wd = wr_data; data = ld_data;
        @(posedge clk);
        if (r) begin
            m_state = S_IDLE; m_ptr = 0; m_cnt = 0; m_wrap = 0; m_err = 0;
            m_ir = '0; m_a = '0; m_tmp = '0;
            m_ir_k = 1; m_a_k = 1; m_tmp_k = 1;
        end else begin
            if ((cir || ca || ct || we) && m_state != S_RUN) m_err = 1;
            if (v && m_state != S_LOAD) m_err = 1;
            if (m_state == S_RUN) begin
                if (cir) begin m_ir = m_mem[mar]; m_ir_k = m_known[mar]; end
                if (ca) begin m_a = m_mem[mar][3:0]; m_a_k = m_known[mar]; end
                if (ct) begin m_tmp = m_mem[mar][3:0]; m_tmp_k = m_known[mar]; end
                if (we) m_mem[mar] = {m_mem[mar][7:4], wd};
            end
            if (m_state == S_LOAD && v) begin
                wa = au ? m_ptr : int'(addr);
                m_mem[wa] = data;
                m_known[wa] = 1;
                if (m_cnt < 16) m_cnt++;
                if (au) begin
                    if (m_ptr == 15) m_wrap = 1;
                    m_ptr = (m_ptr + 1) % 16;
                end
            end
            if (m_state != S_LOAD && lm) begin
                m_state = S_LOAD; m_ptr = 0; m_cnt = 0; m_wrap = 0;
            end else if (m_state != S_LOAD || !lm) begin
                m_state = S_RUN;
            end
        end
        #1;
        chk("ld_ready", {31'd0, ld_ready}, {31'd0, m_state == S_LOAD});
        chk("run_en", {31'd0, run_en}, {31'd0, m_state == S_RUN});
        chk("ld_count", 32'(ld_count), 32'(m_cnt));
        chk("ld_wrap", {31'd0, ld_wrap}, {31'd0, m_wrap});
        chk("err", {31'd0, err}, {31'd0, m_err});
        if (m_ir_k) chk("ir_q", 32'(ir_q), 32'(m_ir));
        if (m_a_k) chk("a_q", 32'(a_q), 32'(m_a));
        if (m_tmp_k) chk("tmp_q", 32'(tmp_q), 32'(m_tmp));
    endtask

    task automatic read_ir(input logic [3:0] addr);
        idle_inputs();
        mar_addr = addr; ce_ir = 1'b1;
        tick();
    endtask

    initial begin
        foreach (m_known[i]) begin m_known[i] = 0; m_mem[i] = '0; end
        m_state = S_IDLE; m_ptr = 0; m_cnt = 0; m_wrap = 0; m_err = 0;
        m_ir_k = 0; m_a_k = 0; m_tmp_k = 0;
        m_ir = '0; m_a = '0; m_tmp = '0;

        b_reset = 1'b1; b_load_mode = 1'b0; b_ld_valid = 1'b0; b_ld_auto = 1'b0;
        b_ld_addr = '0; b_ld_data = '0; b_mar_addr = '0;
        b_ce_ir = 1'b0; b_ce_a = 1'b0; b_ce_tmp = 1'b0; b_we_a = 1'b0; b_wr_data = '0;

        //          rst lm v au addr data  mar cir ca ct we wd   e_ir   e_a   e_tmp err run
        tbl[0]  = '{1, 0, 0, 0, 4'h0, 8'h00, 4'h0, 0, 0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 4'h0, 8'h00, 4'h0, 0, 0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 0, 0};
        tbl[2]  = '{0, 1, 1, 0, 4'h9, 8'h08, 4'h0, 0, 0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 0, 0};
        tbl[3]  = '{0, 1, 1, 0, 4'hA, 8'h0B, 4'h0, 0, 0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 0, 0};
        tbl[4]  = '{0, 1, 1, 0, 4'h0, 8'h79, 4'h0, 0, 0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 4'h0, 8'h00, 4'h0, 0, 0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 0, 1};
        tbl[6]  = '{0, 0, 0, 0, 4'h0, 8'h00, 4'h0, 1, 0, 0, 0, 4'h0, 8'h79, 4'h0, 4'h0, 0, 1};
        tbl[7]  = '{0, 0, 0, 0, 4'h0, 8'h00, 4'h9, 0, 1, 0, 0, 4'h0, 8'h79, 4'h8, 4'h0, 0, 1};
        tbl[8]  = '{0, 0, 0, 0, 4'h0, 8'h00, 4'hA, 0, 0, 1, 0, 4'h0, 8'h79, 4'h8, 4'hB, 0, 1};
        tbl[9]  = '{0, 1, 0, 0, 4'h0, 8'h00, 4'h0, 0, 0, 0, 0, 4'h0, 8'h79, 4'h8, 4'hB, 0, 0};
        tbl[10] = '{0, 1, 1, 0, 4'h9, 8'h78, 4'h0, 0, 0, 0, 0, 4'h0, 8'h79, 4'h8, 4'hB, 0, 0};
        tbl[11] = '{0, 1, 0, 0, 4'h0, 8'h00, 4'h0, 0, 1, 0, 0, 4'h0, 8'h79, 4'h8, 4'hB, 1, 0};
        tbl[12] = '{0, 0, 0, 0, 4'h0, 8'h00, 4'h0, 0, 0, 0, 0, 4'h0, 8'h79, 4'h8, 4'hB, 1, 1};
        tbl[13] = '{0, 0, 0, 0, 4'h0, 8'h00, 4'h9, 1, 0, 0, 1, 4'h5, 8'h78, 4'h8, 4'hB, 1, 1};
        tbl[14] = '{0, 0, 0, 0, 4'h0, 8'h00, 4'h9, 1, 0, 0, 0, 4'h0, 8'h75, 4'h8, 4'hB, 1, 1};
        tbl[15] = '{1, 0, 0, 0, 4'h0, 8'h00, 4'h0, 0, 0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 0, 0};
        tbl[16] = '{0, 0, 0, 0, 4'h0, 8'h00, 4'h0, 0, 0, 0, 0, 4'h0, 8'h00, 4'h0, 4'h0, 0, 1};
        tbl[17] = '{0, 0, 0, 0, 4'h0, 8'h00, 4'h9, 0, 1, 0, 0, 4'h0, 8'h00, 4'h5, 4'h0, 0, 1};

        for (int i = 0; i < 18; i++) begin
            reset = tbl[i].rst; load_mode = tbl[i].lm; ld_valid = tbl[i].v; ld_auto = tbl[i].au;
            ld_addr = tbl[i].addr; ld_data = tbl[i].data; mar_addr = tbl[i].mar;
            ce_ir = tbl[i].cir; ce_a = tbl[i].ca; ce_tmp = tbl[i].ct; we_a = tbl[i].we;
            wr_data = tbl[i].wd;
            tick();
            chk($sformatf("tbl%0d_ir", i), 32'(ir_q), 32'(tbl[i].e_ir));
            chk($sformatf("tbl%0d_a", i), 32'(a_q), 32'(tbl[i].e_a));
            chk($sformatf("tbl%0d_tmp", i), 32'(tmp_q), 32'(tbl[i].e_tmp));
            chk($sformatf("tbl%0d_err", i), {31'd0, err}, {31'd0, tbl[i].e_err});
            chk($sformatf("tbl%0d_run", i), {31'd0, run_en}, {31'd0, tbl[i].e_run});
        end

        // auto load of 17 words wraps the pointer and saturates the count
        idle_inputs(); load_mode = 1'b1; tick();
        for (int i = 0; i < 17; i++) begin
            idle_inputs(); load_mode = 1'b1; ld_valid = 1'b1; ld_auto = 1'b1;
            ld_data = 8'(i);
            tick();
        end
        chk("auto_wrap", {31'd0, ld_wrap}, 32'd1);
        chk("auto_count", 32'(ld_count), 32'd16);
        idle_inputs(); tick();
        read_ir(4'h0); chk("auto_mem0", 32'(ir_q), 32'h10);
        read_ir(4'h1); chk("auto_mem1", 32'(ir_q), 32'h01);

        // reset in the middle of an auto load keeps earlier words
        idle_inputs(); load_mode = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin
            idle_inputs(); load_mode = 1'b1; ld_valid = 1'b1; ld_auto = 1'b1;
            ld_data = 8'hA0 + 8'(i);
            tick();
        end
        chk("mid_count", 32'(ld_count), 32'd3);
        idle_inputs(); reset = 1'b1; load_mode = 1'b1; ld_valid = 1'b1; ld_auto = 1'b1; ld_data = 8'hEE;
        tick();
        chk("rst_count", 32'(ld_count), 32'd0);
        chk("rst_ready", {31'd0, ld_ready}, 32'd0);
        idle_inputs(); tick();
        read_ir(4'h0); chk("keep_mem0", 32'(ir_q), 32'hA0);
        read_ir(4'h1); chk("keep_mem1", 32'(ir_q), 32'hA1);
        read_ir(4'h2); chk("keep_mem2", 32'(ir_q), 32'hA2);
        read_ir(4'h3); chk("abandoned_mem3", 32'(ir_q), 32'h03);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            idle_inputs();
            reset     = ($urandom_range(63) == 0);
            load_mode = (m_state == S_LOAD) ? ($urandom_range(9) != 0) : ($urandom_range(9) == 0);
            ld_valid  = ($urandom_range(3) != 0) ? (m_state == S_LOAD) : 1'($urandom);
            ld_auto   = 1'($urandom);
            ld_addr   = 4'($urandom);
            ld_data   = 8'($urandom);
            mar_addr  = 4'($urandom);
            ce_ir     = ($urandom_range(2) == 0);
            ce_a      = ($urandom_range(2) == 0);
            ce_tmp    = ($urandom_range(2) == 0);
            we_a      = ($urandom_range(3) == 0);
            wr_data   = 4'($urandom);
            tick();
        end

        // wide configuration: top address, operand taken from low bits
        @(posedge clk); #1;
        b_reset = 1'b0; b_load_mode = 1'b1;
        @(posedge clk); #1;
        chk("wide_ready", {31'd0, b_ld_ready}, 32'd1);
        b_ld_valid = 1'b1; b_ld_addr = 6'h3F; b_ld_data = 12'hABC;
        @(posedge clk); #1;
        chk("wide_count", 32'(b_ld_count), 32'd1);
        b_ld_valid = 1'b0; b_load_mode = 1'b0;
        @(posedge clk); #1;
        chk("wide_run", {31'd0, b_run_en}, 32'd1);
        b_mar_addr = 6'h3F; b_ce_tmp = 1'b1; b_ce_ir = 1'b1;
        @(posedge clk); #1;
        chk("wide_tmp", 32'(b_tmp_q), 32'h3C);
        chk("wide_ir", 32'(b_ir_q), 32'hABC);
        chk("wide_err", {31'd0, b_err}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
